sync_fifo_param: RTL and testbench

// - Parametrised single-clock FIFO. Width, depth and almost-flag thresholds are configurable.
// - Accepts a read and a write in the same cycle. Provides an occupancy count and

---
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/sync_fifo_param.sv | 84 ++++++++
 tb/tb_sync_fifo_param.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: producer/consumer requests, read data and status.
// master = the client driving requests, slave = the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              w_en;
    logic [DATA_W-1:0] in_data;
    logic              r_en;
    logic [DATA_W-1:0] out_data;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output w_en, in_data, r_en,
        input  out_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_en, in_data, r_en,
        output out_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is registered read data.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);

    localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   w_ptr_p0;
    logic [ADDR_W:0]   r_ptr_p0;
    logic [ADDR_W:0]   count_p0;
    logic              full_p0;
    logic              empty_p0;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_p1;
    logic              udf_p1;

    // Status decode: purely from registered pointers, no request-to-flag path.
    assign count_p0 = w_ptr_p0 - r_ptr_p0;
    assign empty_p0 = (w_ptr_p0 == r_ptr_p0);
    assign full_p0  = (w_ptr_p0[ADDR_W] != r_ptr_p0[ADDR_W]) &&
                      (w_ptr_p0[ADDR_W-1:0] == r_ptr_p0[ADDR_W-1:0]);

    assign wr_ok = bus.w_en & ~full_p0;
    assign rd_ok = bus.r_en & ~empty_p0;

    assign bus.count        = count_p0;
    assign bus.full         = full_p0;
    assign bus.empty        = empty_p0;
    assign bus.almost_full  = (count_p0 >= AF_CNT);
    assign bus.almost_empty = (count_p0 <= AE_CNT);
    assign bus.overflow     = ovf_p1;
    assign bus.underflow    = udf_p1;

    // Pointer / pulse registers; wrap bit rolls over naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_p0 <= '0;
            r_ptr_p0 <= '0;
            ovf_p1   <= 1'b0;
            udf_p1   <= 1'b0;
        end else begin
            if (wr_ok) w_ptr_p0 <= w_ptr_p0 + 1'b1;
            if (rd_ok) r_ptr_p0 <= r_ptr_p0 + 1'b1;
            ovf_p1 <= bus.w_en & full_p0;
            udf_p1 <= bus.r_en & empty_p0;
        end
    end

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[w_ptr_p0[ADDR_W-1:0]] <= bus.in_data;
    end

`ifdef FIFO_FWFT_EN
    // Head word presented combinationally; r_en pops it.
    assign bus.out_data = empty_p0 ? '0 : mem[r_ptr_p0[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] rd_data_p1;

    // Read data register: loads only on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (rd_ok) begin
            rd_data_p1 <= mem[r_ptr_p0[ADDR_W-1:0]];
        end
    end

    assign bus.out_data = rd_data_p1;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model, directed scenarios, random traffic.
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) b ();

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    // Reference model: the FIFO as a queue, updated at each rising edge.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_out = '0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;

    always @(posedge clk) begin
        int sz;
        logic [DATA_W-1:0] popped;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_out = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = b.w_en && (sz == DEPTH);
            m_udf = b.r_en && (sz == 0);
            if (b.r_en && sz != 0) begin
                popped = q.pop_front();
                m_out  = popped;
            end
            if (b.w_en && sz != DEPTH) q.push_back(b.in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_out();
`ifdef FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : '0;
`else
        return m_out;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",        32'(b.count),        32'(q.size()));
            chk("full",         32'(b.full),         32'(q.size() == DEPTH));
            chk("empty",        32'(b.empty),        32'(q.size() == 0));
            chk("almost_full",  32'(b.almost_full),  32'(q.size() >= AF));
            chk("almost_empty", 32'(b.almost_empty), 32'(q.size() <= AE));
            chk("overflow",     32'(b.overflow),     32'(m_ovf));
            chk("underflow",    32'(b.underflow),    32'(m_udf));
            chk("out_data",     32'(b.out_data),     32'(exp_out()));
        end
    end

    task automatic cyc(input logic we, input logic [DATA_W-1:0] d, input logic re);
        b.w_en    = we;
        b.in_data = d;
        b.r_en    = re;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pw;
        int pr;
        rst       = 1'b1;
        b.w_en    = 1'b0;
        b.r_en    = 1'b0;
        b.in_data = '0;
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        cyc(0, 8'h00, 0);
        chk("rst_empty", 32'(b.empty), 32'd1);
        chk("rst_ae",    32'(b.almost_empty), 32'd1);
        chk("rst_full",  32'(b.full), 32'd0);
        chk("rst_count", 32'(b.count), 32'd0);
        chk("rst_ovf",   32'(b.overflow), 32'd0);
        chk("rst_udf",   32'(b.underflow), 32'd0);
        chk("rst_out",   32'(b.out_data), 32'd0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1, 8'(i), 0);
            chk("fill_count", 32'(b.count), 32'(i));
            if (i == 13) chk("af_at13", 32'(b.almost_full), 32'd0);
            if (i == 14) chk("af_at14", 32'(b.almost_full), 32'd1);
            if (i == 15) chk("full_at15", 32'(b.full), 32'd0);
        end
        chk("full_at16", 32'(b.full), 32'd1);
        cyc(1, 8'hAA, 0);
        chk("ovf_pulse", 32'(b.overflow), 32'd1);
        chk("ovf_count", 32'(b.count), 32'd16);
        cyc(0, 8'h00, 0);
        chk("ovf_drop", 32'(b.overflow), 32'd0);

        // Drain in order
        for (int i = 1; i <= DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
            chk("drain_head", 32'(b.out_data), 32'(i));
            cyc(0, 8'h00, 1);
`else
            cyc(0, 8'h00, 1);
            chk("drain_data", 32'(b.out_data), 32'(i));
`endif
        end
        chk("drain_empty", 32'(b.empty), 32'd1);
        cyc(0, 8'h00, 1);
        chk("udf_pulse", 32'(b.underflow), 32'd1);
`ifdef FIFO_FWFT_EN
        chk("udf_out", 32'(b.out_data), 32'd0);
`else
        chk("udf_hold", 32'(b.out_data), 32'h10);
`endif
        cyc(0, 8'h00, 0);
        chk("udf_drop", 32'(b.underflow), 32'd0);

        // Steady state at count=5 with pointer wrap
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h20 + i), 0);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 8'(8'h30 + k), 1);
            chk("steady_count", 32'(b.count), 32'd5);
`ifndef FIFO_FWFT_EN
            chk("steady_data", 32'(b.out_data), (k < 5) ? 32'(8'h20 + k) : 32'(8'h30 + k - 5));
`endif
        end

        // Simultaneous request at full, then at empty
        for (int i = 0; i < 11; i++) cyc(1, 8'(8'h50 + i), 0);
        chk("refull", 32'(b.full), 32'd1);
        cyc(1, 8'hEE, 1);
        chk("full_rw_ovf",   32'(b.overflow), 32'd1);
        chk("full_rw_count", 32'(b.count), 32'd15);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1);
        chk("reempty", 32'(b.empty), 32'd1);
        cyc(1, 8'h77, 1);
        chk("empty_rw_udf",   32'(b.underflow), 32'd1);
        chk("empty_rw_count", 32'(b.count), 32'd1);
        cyc(0, 8'h00, 1);

        // Reset mid-stream with a concurrent write
        for (int i = 0; i < 7; i++) cyc(1, 8'(8'h60 + i), 0);
        chk("pre_rst_count", 32'(b.count), 32'd7);
        rst = 1'b1;
        cyc(1, 8'h99, 0);
        rst = 1'b0;
        chk("mid_rst_count", 32'(b.count), 32'd0);
        chk("mid_rst_empty", 32'(b.empty), 32'd1);
        cyc(1, 8'h5A, 0);
`ifdef FIFO_FWFT_EN
        chk("fwft_5a", 32'(b.out_data), 32'h5A);
        cyc(0, 8'h00, 1);
`else
        cyc(0, 8'h00, 1);
        chk("std_5a", 32'(b.out_data), 32'h5A);
`endif

        // Random traffic with varying bias and occasional reset
        pw = 50;
        pr = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                pw = $urandom_range(15, 85);
                pr = $urandom_range(15, 85);
            end
            rst = ($urandom_range(0, 299) == 0);
            cyc(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr));
        end
        rst = 1'b0;
        cyc(0, 8'h00, 0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
